// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: three single-entry slots (ALU, load, PC) drained one per
// cycle by round-robin into a registered register-bank write / PC-update port.
module regfile_wb_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_req,
   input  logic [3:0]  alu_reg,
   input  logic [15:0] alu_data,
   output logic        alu_gnt,
   input  logic        mem_req,
   input  logic [3:0]  mem_reg,
   input  logic [15:0] mem_data,
   output logic        mem_gnt,
   input  logic        pc_req,
   input  logic [15:0] pc_data,
   output logic        pc_gnt,
   input  logic [3:0]  src_reg,
   input  logic [3:0]  dst_reg,
   output logic        wr_en,
   output logic [3:0]  wr_reg,
   output logic [15:0] wr_data,
   output logic        pc_inc,
   output logic [15:0] pc_data_in,
   output logic        stall
);

   typedef enum logic [1:0] {PTR_ALU = 2'd0, PTR_MEM = 2'd1, PTR_PC = 2'd2} ptr_t;
   typedef enum logic [1:0] {SEL_NONE = 2'd0, SEL_ALU = 2'd1, SEL_MEM = 2'd2, SEL_PC = 2'd3} sel_t;

   ptr_t        ptr_q, ptr_d;
   sel_t        sel;

   logic        alu_v, mem_v, pc_v;
   logic [3:0]  alu_r, mem_r;
   logic [15:0] alu_d, mem_d, pc_d;

   // Handshake: a requester's write is taken on the rising edge where req and
   // gnt are both 1; gnt is simply "slot empty", so there is no same-cycle bypass.
   assign alu_gnt = ~alu_v;
   assign mem_gnt = ~mem_v;
   assign pc_gnt  = ~pc_v;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ptr_q <= PTR_ALU;
      else      ptr_q <= ptr_d;
   end

   // Search starts at the pointer; pointer moves past whoever wins, holds if idle.
   always_comb begin
      sel   = SEL_NONE;
      ptr_d = ptr_q;
      case (ptr_q)
         PTR_ALU: begin
            if (alu_v)      sel = SEL_ALU;
            else if (mem_v) sel = SEL_MEM;
            else if (pc_v)  sel = SEL_PC;
         end
         PTR_MEM: begin
            if (mem_v)      sel = SEL_MEM;
            else if (pc_v)  sel = SEL_PC;
            else if (alu_v) sel = SEL_ALU;
         end
         default: begin
            if (pc_v)       sel = SEL_PC;
            else if (alu_v) sel = SEL_ALU;
            else if (mem_v) sel = SEL_MEM;
         end
      endcase
      case (sel)
         SEL_ALU: ptr_d = PTR_MEM;
         SEL_MEM: ptr_d = PTR_PC;
         SEL_PC:  ptr_d = PTR_ALU;
         default: ptr_d = ptr_q;
      endcase
   end

   // Capture and issue of one slot are mutually exclusive since gnt = ~valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_v <= 1'b0;
         alu_r <= 4'd0;
         alu_d <= 16'd0;
         mem_v <= 1'b0;
         mem_r <= 4'd0;
         mem_d <= 16'd0;
         pc_v  <= 1'b0;
         pc_d  <= 16'd0;
      end else begin
         if (alu_req && alu_gnt) begin
            alu_v <= 1'b1;
            alu_r <= alu_reg;
            alu_d <= alu_data;
         end else if (sel == SEL_ALU) begin
            alu_v <= 1'b0;
         end
         if (mem_req && mem_gnt) begin
            mem_v <= 1'b1;
            mem_r <= mem_reg;
            mem_d <= mem_data;
         end else if (sel == SEL_MEM) begin
            mem_v <= 1'b0;
         end
         if (pc_req && pc_gnt) begin
            pc_v <= 1'b1;
            pc_d <= pc_data;
         end else if (sel == SEL_PC) begin
            pc_v <= 1'b0;
         end
      end
   end

   // Strobes pulse for one cycle; index/data hold their last values when idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_en      <= 1'b0;
         wr_reg     <= 4'd0;
         wr_data    <= 16'd0;
         pc_inc     <= 1'b0;
         pc_data_in <= 16'd0;
      end else begin
         wr_en  <= (sel == SEL_ALU) || (sel == SEL_MEM);
         pc_inc <= (sel == SEL_PC);
         case (sel)
            SEL_ALU: begin
               wr_reg  <= alu_r;
               wr_data <= alu_d;
            end
            SEL_MEM: begin
               wr_reg  <= mem_r;
               wr_data <= mem_d;
            end
            SEL_PC:  pc_data_in <= pc_d;
            default: ;
         endcase
      end
   end

   // Register 0 is the PC, so a pending or in-flight PC update hazards on r0.
   assign stall = (alu_v && ((src_reg == alu_r) || (dst_reg == alu_r)))
                | (mem_v && ((src_reg == mem_r) || (dst_reg == mem_r)))
                | (wr_en && ((src_reg == wr_reg) || (dst_reg == wr_reg)))
                | ((pc_v || pc_inc) && ((src_reg == 4'd0) || (dst_reg == 4'd0)));

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have ports, clock and reset first (name direction width meaning):
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- alu_req  in  1  ALU write request.
- alu_reg  in  4  ALU destination register.
- alu_data  in  16  ALU result.
- alu_gnt  out  1  ALU slot empty; request accepted when alu_req & alu_gnt.
- mem_req  in  1  load write request.
- mem_reg  in  4  load destination register.
- mem_data  in  16  load data.
- mem_gnt  out  1  load slot empty.
- pc_req  in  1  PC update request.
- pc_data  in  16  new PC value.
- pc_gnt  out  1  PC slot empty.
- src_reg  in  4  register read as operand A this cycle.
- dst_reg  in  4  register read as operand B this cycle.
- wr_en  out  1  register bank write strobe.
- wr_reg  out  4  register bank write index.
- wr_data  out  16  register bank write data.
- pc_inc  out  1  register bank PC update strobe.
- pc_data_in  out  16  register bank PC value.
- stall  out  1  read-after-write hazard on src_reg/dst_reg.
REQ-002 SHALL have no parameters; widths are fixed at 16-bit data and 4-bit register index (16 registers, register 0 = PC).

Function
REQ-003 SHALL hold one single-entry slot per requester (valid, reg, data; the PC slot holds data only).
REQ-004 SHALL capture a slot on the rising edge when its req and gnt are both 1; gnt SHALL be the inverse of the slot's valid bit, with no same-cycle bypass (each requester is limited to 1 write per 2 cycles).
REQ-005 SHALL issue at most one occupied slot per cycle, chosen by 3-way round-robin in the order ALU -> MEM -> PC; the pointer SHALL advance to the requester after the one just issued, and SHALL NOT move when no slot is occupied.
REQ-006 SHALL register the issue outputs: an issued ALU/MEM slot drives wr_en=1, wr_reg, wr_data and pc_inc=0 for exactly one cycle on the next edge; an issued PC slot drives pc_inc=1, pc_data_in and wr_en=0 for exactly one cycle.
REQ-007 SHALL never assert wr_en and pc_inc in the same cycle.
REQ-008 SHALL clear the issued slot on the same edge that loads the output register; acceptance into that slot resumes the following cycle.
REQ-009 SHALL pass ALU/MEM writes to register 0 through as ordinary wr_en writes (they overwrite the PC).
REQ-010 SHALL drive stall combinationally; stall=1 when src_reg or dst_reg equals the reg of any valid ALU/MEM slot or of an active wr_en output, or equals 0 while the PC slot is valid or pc_inc=1.
REQ-011 SHALL hold wr_reg, wr_data and pc_data_in at their last values when idle; strobes SHALL be 0 when idle.
REQ-012 SHALL issue a slot in the cycle it is captured at the earliest, so acceptance-to-strobe latency is 1 cycle minimum and 3 cycles maximum with all slots contending.

Reset
REQ-013 SHALL, while rst=0, asynchronously clear all slot valids, set the pointer to ALU, and drive wr_en=0, pc_inc=0, wr_reg=0, wr_data=0, pc_data_in=0, stall=0, and all gnt=1.
REQ-014 SHALL discard occupied slots and any in-flight strobe if reset asserts mid-operation; after release, the first accepted request issues normally.

Verification
REQ-015 Single ALU: alu_req=1, alu_reg=5, alu_data=0x1234 for 1 cycle -> the next cycle alu_gnt=0; then wr_en=1, wr_reg=5, wr_data=0x1234 for 1 cycle; then alu_gnt=1.
REQ-016 All three requesters in the same cycle (ALU r4=0x0001, MEM r7=0x0002, PC=0x0010) -> strobes issue in order ALU, MEM, PC on consecutive cycles, never overlapping.
REQ-017 Round-robin fairness: ALU and MEM requesting continuously -> wr_reg alternates between the ALU and MEM values; no requester waits more than 2 issues.
REQ-018 Hazard: MEM slot holds r9 with src_reg=9 -> stall=1 until the cycle after the wr_en for r9; stall=1 with dst_reg=0 while the PC update is pending.
REQ-019 Reset mid-operation: rst=0 while all slots are full -> outputs go to 0 immediately with no edge needed; after release no stale write appears.
REQ-020 Illegal overlap check: assertion that wr_en and pc_inc are never both 1, across 10k random requests.
